// File: rtl/regfile_access_arbiter_if.sv
// Bundles the requester, clear-control and register-file signals of the arbiter.
// The master side drives requests and returns the register file's SR1 read data.
interface regfile_access_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             cpu_req;
  logic             cpu_we;
  logic [2:0]       cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_gnt;

  logic             dbg_req;
  logic             dbg_we;
  logic [2:0]       dbg_addr;
  logic [WIDTH-1:0] dbg_wdata;
  logic             dbg_gnt;
  logic [WIDTH-1:0] dbg_rdata;
  logic             dbg_rvalid;

  logic             clr_start;
  logic             clr_busy;
  logic             clr_done;

  logic             rf_ld_reg;
  logic [2:0]       rf_dr;
  logic [WIDTH-1:0] rf_bus;
  logic [2:0]       rf_sr1;
  logic [WIDTH-1:0] rf_sr1_out;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    output clr_start,
    input  clr_busy, clr_done,
    input  rf_ld_reg, rf_dr, rf_bus, rf_sr1,
    output rf_sr1_out
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    input  clr_start,
    output clr_busy, clr_done,
    output rf_ld_reg, rf_dr, rf_bus, rf_sr1,
    input  rf_sr1_out
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Shares the 8-entry register file write port and SR1 read port between the CPU
// writeback path and a debug console, with a starvation guard and a clear sequencer.
module regfile_access_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WIDTH    = 16
) (
  input  logic                          Clk,
  input  logic                          Reset,
  regfile_access_arbiter_if.slave       rf_if
);

  localparam int NREQ    = 2;
  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t           state_reg,      state_next;
  logic [2:0]       clr_idx_reg,    clr_idx_next;
  logic [3:0]       wait_cnt_reg,   wait_cnt_next;
  logic [WIDTH-1:0] dbg_rdata_reg,  dbg_rdata_next;
  logic             dbg_rvalid_reg, dbg_rvalid_next;
  logic             clr_done_reg,   clr_done_next;

  // Requesters flattened into arrays so the steering logic is uniform per requester.
  logic [NREQ-1:0]  req_vec;
  logic [NREQ-1:0]  we_vec;
  logic [2:0]       addr_arr  [NREQ];
  logic [WIDTH-1:0] wdata_arr [NREQ];
  logic [NREQ-1:0]  gnt_vec;

  assign req_vec[REQ_CPU]   = rf_if.cpu_req;
  assign req_vec[REQ_DBG]   = rf_if.dbg_req;
  assign we_vec[REQ_CPU]    = rf_if.cpu_we;
  assign we_vec[REQ_DBG]    = rf_if.dbg_we;
  assign addr_arr[REQ_CPU]  = rf_if.cpu_addr;
  assign addr_arr[REQ_DBG]  = rf_if.dbg_addr;
  assign wdata_arr[REQ_CPU] = rf_if.cpu_wdata;
  assign wdata_arr[REQ_DBG] = rf_if.dbg_wdata;

  logic in_idle;
  logic in_clear;
  logic dbg_starved;
  logic dbg_rd_gnt;

  assign in_idle     = (state_reg == S_IDLE)  && !Reset;
  assign in_clear    = (state_reg == S_CLEAR) && !Reset;
  assign dbg_starved = (wait_cnt_reg == MAX_W) && rf_if.dbg_req;
  assign dbg_rd_gnt  = gnt_vec[REQ_DBG] && !rf_if.dbg_we;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= S_IDLE;
      clr_idx_reg    <= '0;
      wait_cnt_reg   <= '0;
      dbg_rdata_reg  <= '0;
      dbg_rvalid_reg <= 1'b0;
      clr_done_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clr_idx_reg    <= clr_idx_next;
      wait_cnt_reg   <= wait_cnt_next;
      dbg_rdata_reg  <= dbg_rdata_next;
      dbg_rvalid_reg <= dbg_rvalid_next;
      clr_done_reg   <= clr_done_next;
    end
  end

  // Next-state logic; clr_start during CLEAR is deliberately not looked at.
  always_comb begin
    state_next    = state_reg;
    clr_idx_next  = '0;
    clr_done_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (rf_if.clr_start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        clr_idx_next = clr_idx_reg + 3'd1;
        if (clr_idx_reg == 3'd7) begin
          state_next    = S_IDLE;
          clr_done_next = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Wait counter and debug read capture.
  always_comb begin
    wait_cnt_next   = '0;
    dbg_rdata_next  = dbg_rdata_reg;
    dbg_rvalid_next = dbg_rd_gnt;
    if (rf_if.dbg_req && !gnt_vec[REQ_DBG]) begin
      wait_cnt_next = (wait_cnt_reg == MAX_W) ? wait_cnt_reg : wait_cnt_reg + 4'd1;
    end
    if (dbg_rd_gnt) dbg_rdata_next = rf_if.rf_sr1_out;
  end

  // Output logic: arbitration, at most one grant, only in IDLE.
  always_comb begin
    gnt_vec = '0;
    if (in_idle) begin
      if (dbg_starved)           gnt_vec[REQ_DBG] = 1'b1;
      else if (req_vec[REQ_CPU]) gnt_vec[REQ_CPU] = 1'b1;
      else if (req_vec[REQ_DBG]) gnt_vec[REQ_DBG] = 1'b1;
    end
  end

  logic [NREQ-1:0]  ld_term;
  logic [2:0]       addr_term  [NREQ];
  logic [WIDTH-1:0] wdata_term [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign ld_term[gi]    = gnt_vec[gi] & we_vec[gi];
      assign addr_term[gi]  = gnt_vec[gi] ? addr_arr[gi]  : 3'd0;
      assign wdata_term[gi] = gnt_vec[gi] ? wdata_arr[gi] : '0;
    end
  endgenerate

  logic [2:0]       addr_sel;
  logic [WIDTH-1:0] wdata_sel;

  // Grants are one-hot, so OR-ing the masked terms selects the winner.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      addr_sel  = addr_sel  | addr_term[i];
      wdata_sel = wdata_sel | wdata_term[i];
    end
  end

  always_comb begin
    if (in_clear) begin
      rf_if.rf_ld_reg = 1'b1;
      rf_if.rf_dr     = clr_idx_reg;
      rf_if.rf_bus    = '0;
      rf_if.rf_sr1    = '0;
    end else begin
      rf_if.rf_ld_reg = |ld_term;
      rf_if.rf_dr     = addr_sel;
      rf_if.rf_bus    = wdata_sel;
      rf_if.rf_sr1    = addr_sel;
    end
  end

  assign rf_if.cpu_gnt    = gnt_vec[REQ_CPU];
  assign rf_if.dbg_gnt    = gnt_vec[REQ_DBG];
  assign rf_if.dbg_rdata  = dbg_rdata_reg;
  assign rf_if.dbg_rvalid = dbg_rvalid_reg;
  assign rf_if.clr_busy   = in_clear;
  assign rf_if.clr_done   = clr_done_reg;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter: a small register file, a cycle model
// of the arbitration rules checked every cycle, and literal checks per scenario.
module tb_regfile_access_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int WIDTH    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_access_arbiter_if #(.WIDTH(WIDTH)) rf_if ();

  regfile_access_arbiter #(.MAX_WAIT(MAX_WAIT), .WIDTH(WIDTH)) dut (
    .Clk   (clk),
    .Reset (rst),
    .rf_if (rf_if)
  );

  // The register file the arbiter sits in front of.
  logic [WIDTH-1:0] rf_mem [8];
  always @(posedge clk) if (rf_if.rf_ld_reg) rf_mem[rf_if.rf_dr] <= rf_if.rf_bus;
  assign rf_if.rf_sr1_out = rf_mem[rf_if.rf_sr1];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_regs [8];
  bit               m_known [8];
  int               m_wait = 0, m_k = 0, m_win = 0;
  bit               m_clear = 0, m_rvalid = 0, m_rknown = 0, m_done = 0, m_live = 0;
  logic [WIDTH-1:0] m_rdata = '0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_cpu_gnt", rf_if.cpu_gnt, 0);
      chk("rst_dbg_gnt", rf_if.dbg_gnt, 0);
      chk("rst_ld_reg", rf_if.rf_ld_reg, 0);
      chk("rst_clr_busy", rf_if.clr_busy, 0);
      m_clear = 0; m_k = 0; m_wait = 0; m_rvalid = 0; m_done = 0;
      m_rdata = '0; m_rknown = 1; m_live = 1;
    end else if (m_live) begin
      chk("m_rvalid", rf_if.dbg_rvalid, m_rvalid);
      if (m_rvalid && m_rknown) chk("m_rdata", rf_if.dbg_rdata, m_rdata);
      chk("m_clr_done", rf_if.clr_done, m_done);
      if (m_clear) begin
        chk("m_busy", rf_if.clr_busy, 1);
        chk("m_clr_ld", rf_if.rf_ld_reg, 1);
        chk("m_clr_dr", rf_if.rf_dr, m_k);
        chk("m_clr_bus", rf_if.rf_bus, 0);
        chk("m_clr_gnt", {rf_if.cpu_gnt, rf_if.dbg_gnt}, 0);
        m_regs[m_k] = '0; m_known[m_k] = 1;
        m_wait   = rf_if.dbg_req ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
        m_rvalid = 0;
        m_done   = (m_k == 7);
        m_k++;
        if (m_k == 8) begin m_clear = 0; m_k = 0; end
      end else begin
        m_win = 0;
        if (rf_if.dbg_req && m_wait >= MAX_WAIT) m_win = 2;
        else if (rf_if.cpu_req)                  m_win = 1;
        else if (rf_if.dbg_req)                  m_win = 2;
        chk("m_cpu_gnt", rf_if.cpu_gnt, m_win == 1);
        chk("m_dbg_gnt", rf_if.dbg_gnt, m_win == 2);
        chk("m_busy", rf_if.clr_busy, 0);
        m_rvalid = 0;
        if (m_win == 1) begin
          chk("m_cpu_ld", rf_if.rf_ld_reg, rf_if.cpu_we);
          chk("m_cpu_dr", rf_if.rf_dr, rf_if.cpu_addr);
          chk("m_cpu_sr1", rf_if.rf_sr1, rf_if.cpu_addr);
          chk("m_cpu_bus", rf_if.rf_bus, rf_if.cpu_wdata);
          if (!rf_if.cpu_we && m_known[rf_if.cpu_addr])
            chk("m_cpu_rd", rf_if.rf_sr1_out, m_regs[rf_if.cpu_addr]);
          if (rf_if.cpu_we) begin
            m_regs[rf_if.cpu_addr] = rf_if.cpu_wdata; m_known[rf_if.cpu_addr] = 1;
          end
        end else if (m_win == 2) begin
          chk("m_dbg_ld", rf_if.rf_ld_reg, rf_if.dbg_we);
          chk("m_dbg_dr", rf_if.rf_dr, rf_if.dbg_addr);
          chk("m_dbg_sr1", rf_if.rf_sr1, rf_if.dbg_addr);
          chk("m_dbg_bus", rf_if.rf_bus, rf_if.dbg_wdata);
          if (rf_if.dbg_we) begin
            m_regs[rf_if.dbg_addr] = rf_if.dbg_wdata; m_known[rf_if.dbg_addr] = 1;
          end else begin
            m_rvalid = 1;
            m_rdata  = m_regs[rf_if.dbg_addr];
            m_rknown = m_known[rf_if.dbg_addr];
          end
        end else begin
          chk("m_idle_ld", rf_if.rf_ld_reg, 0);
          chk("m_idle_dr", rf_if.rf_dr, 0);
          chk("m_idle_sr1", rf_if.rf_sr1, 0);
          chk("m_idle_bus", rf_if.rf_bus, 0);
        end
        m_wait = (rf_if.dbg_req && m_win != 2) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
        m_done = 0;
        if (rf_if.clr_start) begin m_clear = 1; m_k = 0; end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    rf_if.cpu_req = 0; rf_if.cpu_we = 0; rf_if.cpu_addr = 0; rf_if.cpu_wdata = 0;
    rf_if.dbg_req = 0; rf_if.dbg_we = 0; rf_if.dbg_addr = 0; rf_if.dbg_wdata = 0;
    rf_if.clr_start = 0;
  endtask

  task automatic wait_gnt(input bit is_dbg, input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = is_dbg ? rf_if.dbg_gnt : rf_if.cpu_gnt;
      tick();
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL %s grant timeout got=0 expected=1", name);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [WIDTH-1:0] d);
    rf_if.cpu_req = 1; rf_if.cpu_we = 1; rf_if.cpu_addr = a; rf_if.cpu_wdata = d;
    wait_gnt(0, "cpu_write");
    rf_if.cpu_req = 0;
  endtask

  task automatic dbg_read(input logic [2:0] a, output logic [WIDTH-1:0] d);
    rf_if.dbg_req = 1; rf_if.dbg_we = 0; rf_if.dbg_addr = a;
    wait_gnt(1, "dbg_read");
    rf_if.dbg_req = 0;
    @(negedge clk);
    chk("dbg_read_rvalid", rf_if.dbg_rvalid, 1);
    d = rf_if.dbg_rdata;
    tick();
  endtask

  task automatic watch_clear(input int restart_at, output int busy, output int done, output int bad);
    bit got_cpu = 0;
    busy = 0; done = 0; bad = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (rf_if.clr_busy) begin
        if (rf_if.rf_dr != 3'(busy) || rf_if.rf_bus != 0 || !rf_if.rf_ld_reg ||
            rf_if.cpu_gnt || rf_if.dbg_gnt) bad++;
        busy++;
      end
      if (rf_if.clr_done) done++;
      if (rf_if.cpu_gnt) got_cpu = 1;
      tick();
      rf_if.clr_start = (busy == restart_at);
      if (got_cpu) rf_if.cpu_req = 0;
    end
    rf_if.clr_start = 0;
  endtask

  // ---------------- directed scenarios ----------------
  logic [WIDTH-1:0] rd;
  logic [9:0]       dpat, cpat;
  int               busy, done, bad;

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_in();
    rst = 1;
    tick(); tick();
    @(negedge clk);
    chk("reset_rvalid", rf_if.dbg_rvalid, 0);
    chk("reset_done", rf_if.clr_done, 0);
    chk("reset_rdata", rf_if.dbg_rdata, 0);
    tick();
    rst = 0;

    // CPU write R3, then debug read R3.
    rf_if.cpu_req = 1; rf_if.cpu_we = 1; rf_if.cpu_addr = 3; rf_if.cpu_wdata = 16'h1234;
    @(negedge clk);
    chk("t1_cpu_gnt", rf_if.cpu_gnt, 1);
    chk("t1_ld_dr", {rf_if.rf_ld_reg, rf_if.rf_dr}, {1'b1, 3'd3});
    chk("t1_bus", rf_if.rf_bus, 16'h1234);
    tick();
    rf_if.cpu_req = 0;
    rf_if.dbg_req = 1; rf_if.dbg_we = 0; rf_if.dbg_addr = 3;
    @(negedge clk);
    chk("t1_dbg_gnt", rf_if.dbg_gnt, 1);
    chk("t1_sr1", rf_if.rf_sr1, 3);
    tick();
    rf_if.dbg_req = 0;
    @(negedge clk);
    chk("t1_rvalid", rf_if.dbg_rvalid, 1);
    chk("t1_rdata", rf_if.dbg_rdata, 16'h1234);
    tick();

    // Both requesting continuously: debug wins every fifth cycle.
    rf_if.cpu_req = 1; rf_if.cpu_we = 0; rf_if.cpu_addr = 3;
    rf_if.dbg_req = 1; rf_if.dbg_we = 0; rf_if.dbg_addr = 3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dpat[i] = rf_if.dbg_gnt;
      cpat[i] = rf_if.cpu_gnt;
      tick();
    end
    idle_in();
    chk("t2_dbg_pattern", dpat, 10'h210);
    chk("t2_cpu_pattern", cpat, 10'h1EF);
    tick();

    // Preload FFFF, clear with CPU requesting throughout.
    for (int a = 0; a < 8; a++) cpu_write(3'(a), 16'hFFFF);
    rf_if.clr_start = 1;
    tick();
    rf_if.clr_start = 0;
    rf_if.cpu_req = 1; rf_if.cpu_we = 0; rf_if.cpu_addr = 2;
    watch_clear(-1, busy, done, bad);
    chk("t3_busy_cycles", busy, 8);
    chk("t3_done_pulses", done, 1);
    chk("t3_step_errors", bad, 0);
    idle_in();
    for (int a = 0; a < 8; a++) begin
      dbg_read(3'(a), rd);
      chk("t3_cleared", rd, 16'h0000);
    end

    // Clear started together with a CPU write; second clr_start in the 3rd cycle.
    rf_if.cpu_req = 1; rf_if.cpu_we = 1; rf_if.cpu_addr = 6; rf_if.cpu_wdata = 16'h1111;
    rf_if.clr_start = 1;
    @(negedge clk);
    chk("t4_cpu_gnt_with_start", rf_if.cpu_gnt, 1);
    tick();
    idle_in();
    watch_clear(2, busy, done, bad);
    chk("t4_busy_cycles", busy, 8);
    chk("t4_done_pulses", done, 1);
    chk("t4_step_errors", bad, 0);

    // Reset in the 4th CLEAR cycle after preload AAAA.
    for (int a = 0; a < 8; a++) cpu_write(3'(a), 16'hAAAA);
    rf_if.clr_start = 1;
    tick();
    rf_if.clr_start = 0;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    watch_clear(-1, busy, done, bad);
    chk("t5_busy_after_reset", busy, 0);
    chk("t5_no_done", done, 0);
    for (int a = 0; a < 8; a++) begin
      dbg_read(3'(a), rd);
      chk("t5_partial", rd, (a < 3) ? 16'h0000 : 16'hAAAA);
    end

    // Debug write R5, then CPU read of R5.
    rf_if.dbg_req = 1; rf_if.dbg_we = 1; rf_if.dbg_addr = 5; rf_if.dbg_wdata = 16'h00FF;
    @(negedge clk);
    chk("t6_dbg_gnt", rf_if.dbg_gnt, 1);
    chk("t6_ld_dr", {rf_if.rf_ld_reg, rf_if.rf_dr}, {1'b1, 3'd5});
    tick();
    idle_in();
    rf_if.cpu_req = 1; rf_if.cpu_we = 0; rf_if.cpu_addr = 5;
    @(negedge clk);
    chk("t6_no_rvalid", rf_if.dbg_rvalid, 0);
    chk("t6_cpu_gnt", rf_if.cpu_gnt, 1);
    chk("t6_cpu_rd", rf_if.rf_sr1_out, 16'h00FF);
    tick();
    idle_in();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
